// File: rtl/mem_dma.sv
// Word-granular memory-to-memory copier: one READ then one WRITE cycle per word, ascending addresses.
// Latency 2*L+1 cycles from accepted start to end of done_o; no backpressure (memory is single-cycle).
module mem_dma #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [31:0]      src_i,
  input  logic [31:0]      dst_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [LEN_W-1:0] count_o,
  output logic             we_o,
  output logic [31:0]      addr_o,
  output logic [31:0]      data_o,
  input  logic [31:0]      data_i
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  typedef struct packed {
    logic [29:0]      src;
    logic [29:0]      dst;
    logic [LEN_W-1:0] len;
  } cfg_t;

  state_t           state_q, state_d;
  cfg_t             cfg_q, cfg_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [31:0]      buf_q, buf_d;
  logic [LEN_W-1:0] idx_inc;
  logic [29:0]      src_word, dst_word;
  logic             unused_addr_lsbs;

  // Byte offsets are dropped; word arithmetic wraps naturally at 30 bits.
  assign unused_addr_lsbs = ^{src_i[1:0], dst_i[1:0]};
  assign idx_inc  = idx_q + LEN_W'(1);
  assign src_word = cfg_q.src + 30'(idx_q);
  assign dst_word = cfg_q.dst + 30'(idx_q);
  assign count_o  = cnt_q;

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    busy_o  = 1'b1;
    done_o  = 1'b0;
    we_o    = 1'b0;
    addr_o  = '0;
    data_o  = '0;
    case (state_q)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          cnt_d = '0;
          if (len_i != '0) begin
            cfg_d.src = src_i[31:2];
            cfg_d.dst = dst_i[31:2];
            cfg_d.len = len_i;
            idx_d     = '0;
            state_d   = READ;
          end else begin
            state_d = DONE;
          end
        end
      end
      READ: begin
        addr_o  = {src_word, 2'b00};
        buf_d   = data_i;
        state_d = abort_i ? DONE : WRITE;
      end
      WRITE: begin
        addr_o  = {dst_word, 2'b00};
        we_o    = 1'b1;
        data_o  = buf_q;
        idx_d   = idx_inc;
        cnt_d   = cnt_q + LEN_W'(1);
        // An abort here still lets the current write land.
        state_d = (abort_i || (idx_inc >= cfg_q.len)) ? DONE : READ;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_mem_dma.sv
// Bench for mem_dma: per-copy expected output trace built from a word-level copy model, checked every cycle.
module tb_mem_dma;
  localparam int LW = 16;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          we;
    logic [31:0]   addr;
    logic [31:0]   data;
    logic [LW-1:0] count;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic [31:0]   src_i = '0;
  logic [31:0]   dst_i = '0;
  logic [LW-1:0] len_i = '0;
  logic          busy_o, done_o, we_o;
  logic [LW-1:0] count_o;
  logic [31:0]   addr_o, data_o, data_i;

  always #5 clk = ~clk;

  mem_dma #(.LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .src_i(src_i), .dst_i(dst_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .count_o(count_o),
    .we_o(we_o), .addr_o(addr_o), .data_o(data_o), .data_i(data_i)
  );

  // Memory seen by the DUT (4 KB, aliased) and the model's copy of it.
  logic [31:0] ram  [0:1023];
  logic [31:0] mram [0:1023];
  logic        poke_en = 1'b0;
  logic [9:0]  poke_a = '0;
  logic [31:0] poke_d = '0;

  function automatic logic [31:0] init_word(input int i);
    logic [31:0] v;
    v = i;
    return {v[15:0] ^ 16'h5A5A, ~v[15:0]};
  endfunction

  assign data_i = ram[addr_o[11:2]];

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (we_o) ram[addr_o[11:2]] <= data_o;
      else if (poke_en) ram[poke_a] <= poke_d;
    end
  end

  exp_t          exp_q[$];
  logic [LW-1:0] exp_count = '0;
  int            n_cmp = 0;
  int            n_bad = 0;
  bit            cmp_en = 1'b0;
  int            cyc = 0;
  int            start_cyc = 0;
  int            last_done_cyc = -1;
  logic [31:0]   last_rd = '0;
  logic [31:0]   last_wr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input logic b, input logic dn, input logic w,
                              input logic [31:0] a, input logic [31:0] dt,
                              input logic [LW-1:0] c);
    exp_t e;
    e.busy = b; e.done = dn; e.we = w; e.addr = a; e.data = dt; e.count = c;
    return e;
  endfunction

  // Per-cycle comparison; an empty trace means the DUT must sit idle.
  always @(negedge clk) begin
    exp_t e, a;
    if (cmp_en) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, exp_count);
      a = mk(busy_o, done_o, we_o, addr_o, data_o, count_o);
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL cycle_outputs t=%0t busy/done/we=%b%b%b addr=%h data=%h count=%0d, expected %b%b%b addr=%h data=%h count=%0d",
                 $time, a.busy, a.done, a.we, a.addr, a.data, a.count,
                 e.busy, e.done, e.we, e.addr, e.data, e.count);
      end
    end
    if (done_o) last_done_cyc = cyc;
    if (busy_o && !done_o && !we_o) last_rd = addr_o;
    if (we_o) last_wr = addr_o;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [31:0] v);
    @(posedge clk); #1;
    poke_en = 1'b1; poke_a = a[11:2]; poke_d = v;
    mram[a[11:2]] = v;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  // Builds the expected cycle trace word by word, then drives the copy.
  // abort_at / rst_at: cycle index after the start edge (1 = first READ), 0 = none.
  task automatic do_copy(input logic [31:0] s, input logic [31:0] d, input int len,
                         input int abort_at, input int rst_at);
    logic [29:0]   sw, dw, ra, wa;
    logic [31:0]   rv;
    logic [LW-1:0] cnt;
    int            n;
    bit            fin, was_rst;
    @(posedge clk); #1;
    start_cyc = cyc;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, exp_count));
    start_i = 1'b1; src_i = s; dst_i = d; len_i = LW'(len);
    sw = s[31:2]; dw = d[31:2]; cnt = '0; n = 0; fin = 1'b0;
    for (int i = 0; i < len && !fin; i++) begin
      ra = sw + 30'(i);
      wa = dw + 30'(i);
      n++;
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, {ra, 2'b00}, 32'h0, cnt));
      if (n == rst_at) fin = 1'b1;
      else if (n == abort_at) begin
        n++;
        exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, cnt));
        fin = 1'b1;
      end
      if (!fin) begin
        rv = mram[ra[9:0]];
        n++;
        exp_q.push_back(mk(1'b1, 1'b0, 1'b1, {wa, 2'b00}, rv, cnt));
        mram[wa[9:0]] = rv;
        cnt++;
        if (n == rst_at) fin = 1'b1;
        else if (n == abort_at || i == len - 1) begin
          n++;
          exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, cnt));
          fin = 1'b1;
        end
      end
    end
    if (len == 0) begin
      n = 1;
      exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, '0));
    end
    was_rst = (rst_at >= 1) && (rst_at <= n);
    exp_count = was_rst ? '0 : cnt;
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      start_i = 1'($urandom_range(0, 1));
      src_i   = $urandom;
      dst_i   = $urandom;
      len_i   = LW'($urandom);
      abort_i = (c == abort_at) || (c == n && !was_rst && $urandom_range(0, 1) == 1);
      rst     = (c == rst_at);
    end
    @(posedge clk); #1;
    start_i = 1'b0; rst = 1'b0;
    abort_i = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    abort_i = 1'b0;
  endtask

  initial begin
    logic [31:0] pat [4];
    int len, ab, rs;
    pat[0] = 32'hA0A0_0001; pat[1] = 32'hB0B0_0002;
    pat[2] = 32'hC0C0_0003; pat[3] = 32'hD0D0_0004;
    for (int i = 0; i < 1024; i++) mram[i] = init_word(i);

    @(posedge clk); #1;
    cmp_en = 1'b1;
    check("reset_busy", {31'h0, busy_o}, 32'h0);
    check("reset_count", 32'(count_o), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 4; i++) poke(32'h100 + 32'(4 * i), pat[i]);
    do_copy(32'h100, 32'h200, 4, 0, 0);
    for (int i = 0; i < 4; i++) check($sformatf("basic_copy_w%0d", i), ram[10'h80 + 10'(i)], pat[i]);
    check("basic_count", 32'(count_o), 32'd4);
    check("basic_done_cycle", 32'(last_done_cyc - start_cyc), 32'd9);

    do_copy(32'h500, 32'h600, 0, 0, 0);
    check("len0_count", 32'(count_o), 32'd0);
    check("len0_done_cycle", 32'(last_done_cyc - start_cyc), 32'd1);

    do_copy(32'h103, 32'h201, 1, 0, 0);
    check("unaligned_rd_addr", last_rd, 32'h100);
    check("unaligned_wr_addr", last_wr, 32'h200);

    do_copy(32'h100, 32'h300, 4, 3, 0);
    check("abort_read_count", 32'(count_o), 32'd1);
    do_copy(32'h100, 32'h300, 4, 4, 0);
    check("abort_write_count", 32'(count_o), 32'd2);

    do_copy(32'h100, 32'h380, 4, 0, 4);
    check("rst_mid_count", 32'(count_o), 32'd0);
    do_copy(32'h100, 32'h380, 4, 0, 0);
    check("after_rst_count", 32'(count_o), 32'd4);

    poke(32'h100, 32'hDEAD_BEEF);
    do_copy(32'h100, 32'h104, 3, 0, 0);
    for (int i = 1; i < 4; i++) check($sformatf("overlap_w%0d", i), ram[10'h40 + 10'(i)], 32'hDEAD_BEEF);

    do_copy(32'hFFFF_FFF8, 32'h0000_0010, 4, 0, 0);
    check("wrap_last_rd", last_rd, 32'h0000_0004);

    for (int k = 0; k < 40; k++) begin
      len = $urandom_range(0, 8);
      ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2 * len + 1) : 0;
      rs  = (ab == 0 && $urandom_range(0, 7) == 0) ? $urandom_range(1, 2 * len + 1) : 0;
      do_copy($urandom, $urandom, len, ab, rs);
    end

    repeat (3) @(posedge clk);
    #1;
    check("trace_drained", 32'(exp_q.size()), 32'h0);
    for (int i = 0; i < 1024; i++) check($sformatf("ram_w%0d", i), ram[i], mram[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_dma.md
MEM_DMA -- requirements
Module: mem_dma

Interface
REQ-001 SHALL have parameter LEN_W, default 16, meaning the width of the transfer-length field in 32-bit words.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start_i  input  1  request a copy; sampled only in IDLE.
REQ-005 SHALL have port abort_i  input  1  request early termination of an active copy.
REQ-006 SHALL have port src_i  input  32  source byte address, latched on start.
REQ-007 SHALL have port dst_i  input  32  destination byte address, latched on start.
REQ-008 SHALL have port len_i  input  LEN_W  word count, latched on start.
REQ-009 SHALL have port busy_o  output  1  high in any state other than IDLE.
REQ-010 SHALL have port done_o  output  1  one-cycle completion pulse.
REQ-011 SHALL have port count_o  output  LEN_W  words written so far in the current or last copy.
REQ-012 SHALL have port we_o  output  1  memory write enable.
REQ-013 SHALL have port addr_o  output  32  memory byte address, with bits [1:0] always 0.
REQ-014 SHALL have port data_o  output  32  memory write data.
REQ-015 SHALL have port data_i  input  32  memory read data, valid combinationally in the same cycle as addr_o.

Function
REQ-016 SHALL implement an FSM with states IDLE, READ, WRITE, DONE, encoded in registers only.
REQ-017 IDLE: when start_i=1 and len_i!=0, SHALL latch src_i[31:2], dst_i[31:2] and len_i, clear the index and count_o, and go to READ on the next edge.
REQ-018 IDLE: when start_i=1 and len_i=0, SHALL clear count_o and go directly to DONE with no memory access.
REQ-019 READ: SHALL drive addr_o={src[31:2]+idx,2'b00} and we_o=0, capture data_i into the word buffer at the edge, then go to WRITE.
REQ-020 WRITE: SHALL drive addr_o={dst[31:2]+idx,2'b00}, we_o=1 and data_o=buffer, increment idx and count_o at the edge, then go to READ if idx+1<len or to DONE otherwise.
REQ-021 DONE: SHALL assert done_o for exactly one cycle, then go to IDLE.
REQ-022 SHALL take 2*L+1 cycles from the start-sampling edge to the end of done_o for a length L>0.
REQ-023 SHALL wrap address arithmetic modulo 2^30 words, with no carry into or out of bits [1:0].
REQ-024 SHALL ignore the low two bits of src_i and dst_i.
REQ-025 SHALL always copy forward in ascending addresses; overlapping regions with dst>src SHALL propagate already-copied words, and this is defined behaviour.
REQ-026 SHALL ignore start_i while busy_o=1; latched parameters SHALL NOT change mid-copy.
REQ-027 abort_i=1 in READ SHALL go to DONE at the next edge without writing the pending word.
REQ-028 abort_i=1 in WRITE SHALL complete that write (count_o increments) and then go to DONE.
REQ-029 abort_i SHALL be ignored in IDLE and DONE.
REQ-030 abort_i and the final WRITE in the same cycle SHALL go to DONE, indistinguishable from normal completion.
REQ-031 outside WRITE, we_o SHALL be 0 and data_o SHALL be 0.
REQ-032 outside READ and WRITE, addr_o SHALL be 0.
REQ-033 count_o SHALL hold its final value in IDLE until the next accepted start.

Reset
REQ-034 rst=1 at a rising edge SHALL force IDLE and clear idx, count_o, buffer and latched parameters, from any state including mid-copy.
REQ-035 during and immediately after reset, busy_o, done_o and we_o SHALL be 0 and addr_o and data_o SHALL be 0.
REQ-036 a write in progress when reset is sampled SHALL still occur at that edge; no further writes SHALL follow.

Verification
REQ-037 Preload RAM[0x100..0x10C]=A,B,C,D; start src=0x100, dst=0x200, len=4 -> RAM[0x200..0x20C]=A,B,C,D; done_o pulses at cycle 9; count_o=4.
REQ-038 Start with len=0 -> no we_o; done_o in the next cycle; count_o=0.
REQ-039 src=0x103, dst=0x201, len=1 -> read address 0x100, write address 0x200.
REQ-040 Apply abort_i in the second READ of len=4 -> exactly 1 word written, count_o=1; abort_i in the second WRITE -> 2 words written, count_o=2.
REQ-041 Assert rst=1 in the WRITE for word 2 of len=4 -> IDLE next cycle; count_o=0; no writes after that edge; a new start then works normally.
REQ-042 Overlap src=0x100, dst=0x104, len=3, RAM[0x100]=X -> RAM[0x104..0x10C]=X,X,X; start_i pulses while busy have no effect.
